// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//
// Elastic pipeline register placed between the fetch/decode/execute/memory/
// writeback stages. A packed stage struct of WIDTH bits travels through a
// DEPTH-entry circular buffer using a valid/ready handshake. A synchronous
// flush squashes every held entry when a branch or jump redirects the front
// end. A saturating counter records how many cycles the producer was stalled.
//
// Optional feature (compile-time macro PIPE_STAGE_BYPASS_EN):
//   When defined, an empty buffer whose consumer is ready forwards in_data
//   straight to out_data in the same cycle without storing it. This restores
//   the zero-latency behaviour of the old fixed latch path when the pipe is
//   not stalled. When undefined, every entry spends at least one cycle in the
//   buffer and there is no combinational path from in_* to out_*.
//
// Parameters:
//   WIDTH  payload width; set to $bits of the stage struct carried
//   DEPTH  number of entries; a power of two, at least 2
//   CNT_W  width of the occupancy output (derived, do not override)
//
// Ports:
//   CLK           rising-edge clock
//   nRST          asynchronous active-low reset
//   flush         synchronous squash of all held entries
//   in_valid      producer presents in_data
//   in_ready      buffer can accept an entry this cycle
//   in_data       producer payload
//   out_valid     out_data holds a valid entry
//   out_ready     consumer accepts out_data this cycle
//   out_data      oldest held entry (zero when the buffer is empty)
//   count         current occupancy, 0..DEPTH
//   stall_cycles  saturating count of cycles with in_valid=1 and in_ready=0
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      stall_cycles
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Pointer wrap relies on natural binary overflow, so a non-power-of-two
  // depth would silently skip or reuse entries.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be a power of two and at least 2");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  logic is_empty;
  logic is_full;
  logic bypass;
  logic push;
  logic pop;

  // -------------------------------------------------------------------------
  // Occupancy decode and handshake
  // -------------------------------------------------------------------------
  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == FULL_CNT);
    // in_ready looks only at registered occupancy and flush, never at
    // out_ready, so a full buffer cannot accept even while it drains.
    in_ready = ~is_full & ~flush;
  end

  // Same-cycle forwarding is only possible when nothing older is queued,
  // the consumer takes the word right away and no squash is in progress.
  always_comb begin
`ifdef PIPE_STAGE_BYPASS_EN
    bypass = is_empty & in_valid & out_ready & ~flush;
`else
    bypass = 1'b0;
`endif
  end

  always_comb begin
    out_valid = (~is_empty & ~flush) | bypass;
    out_data  = is_empty ? '0 : mem_q[rd_ptr_q];
    if (bypass) begin
      out_data = in_data;
    end
    // A forwarded word is consumed on the spot, so it is never stored.
    push = in_valid & in_ready & ~bypass;
    pop  = ~is_empty & ~flush & out_ready;
  end

  // -------------------------------------------------------------------------
  // Next-state for storage, pointers and occupancy. Flush wins over any
  // push or pop and rewinds both pointers, but leaves the storage alone.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Back-pressure counter. Flush cycles also count because the producer is
  // still being held off; the counter sticks at all-ones until reset.
  // -------------------------------------------------------------------------
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (in_valid && !in_ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_q          <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      stall_cycles_q <= '0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign count        = count_q;
  assign stall_cycles = stall_cycles_q;

  // -------------------------------------------------------------------------
  // Structural invariants
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0] ptr_diff;
  assign ptr_diff = wr_ptr_q - rd_ptr_q;

  a_count_bound : assert property (
    @(posedge CLK) disable iff (!nRST) count_q <= FULL_CNT
  );

  // When full the pointers coincide, exactly as they do when empty.
  a_ptr_consistent : assert property (
    @(posedge CLK) disable iff (!nRST)
    is_full ? (ptr_diff == '0) : (count_q == CNT_W'(ptr_diff))
  );

  a_no_push_when_full : assert property (
    @(posedge CLK) disable iff (!nRST) push |-> !is_full
  );

  a_no_pop_when_empty : assert property (
    @(posedge CLK) disable iff (!nRST) pop |-> !is_empty
  );

  a_flush_empties : assert property (
    @(posedge CLK) disable iff (!nRST) flush |=> (count_q == '0)
  );

endmodule
